// File: rtl/ship_rotation.sv
// ship_rotation: samples rotate buttons at the rotation rate, keeps a wrapping
// angle index and converts it to signed 1.17 sin/cos words through a
// quarter-wave table. Define SHIP_ROT_HOLD_EN to enable the hold delay.
module ship_rotation #(
  parameter int ANGLE_STEPS = 32,
  parameter int DIVIDER     = 125_000,
  parameter int CLK_RATE    = 25_000_000,
  parameter int ROT_RATE    = 20,
  parameter int HOLD_TICKS  = 3
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           rot_left,
  input  logic                           rot_right,
  output logic [$clog2(ANGLE_STEPS)-1:0] angle,
  output logic signed [17:0]             sin_val,
  output logic signed [17:0]             cos_val
);

  localparam int unsigned AW  = $clog2(ANGLE_STEPS);
  localparam int unsigned QTR = ANGLE_STEPS / 4;
  localparam int unsigned RD  = CLK_RATE / DIVIDER / ROT_RATE;
  localparam int unsigned FW  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned RW  = (RD > 1) ? $clog2(RD) : 1;
  localparam longint      ONE = 64'sd1073741824;  // 2^30 fixed-point unit

  // Reject parameter sets the folding and counters cannot represent
  if (ANGLE_STEPS < 8 || (ANGLE_STEPS & (ANGLE_STEPS - 1)) != 0 ||
      RD < 1 || HOLD_TICKS < 0) begin : g_bad_cfg
    $error("ship_rotation: unsupported parameter set");
  end

  // round(131071*sin(k*pi/(2*QTR))) via fixed-point Taylor series, elaboration only
  function automatic logic [16:0] sin_entry(input int k);
    longint x, x2, term, sum, r;
    x    = (longint'(k) * 64'sd3373259426) / longint'(2 * QTR);
    x2   = (x * x) / ONE;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * x2) / ONE) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * 64'sd131071 + ONE / 2) / ONE;
    if (r > 64'sd131071) r = 64'sd131071;
    if (r < 64'sd0)      r = 64'sd0;
    return 17'(r);
  endfunction

  logic [16:0] quarter [QTR+1];

  for (genvar g = 0; g <= QTR; g++) begin : g_table
    localparam logic [16:0] ENTRY = sin_entry(g);
    assign quarter[g] = ENTRY;
  end

  // Quadrant fold: bit AW-2 mirrors the index, bit AW-1 negates the result
  function automatic logic signed [17:0] fold(input logic [AW-1:0] a);
    logic [AW-2:0] idx;
    logic [16:0]   mag;
    idx = a[AW-2] ? ((AW-1)'(QTR) - {1'b0, a[AW-3:0]}) : {1'b0, a[AW-3:0]};
    mag = quarter[idx];
    return a[AW-1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] rot_cnt;
  logic          frame_tick_c;
  logic          rot_tick_c;
  logic          step_up_c;
  logic          step_dn_c;

  assign frame_tick_c = (frame_cnt == FW'(DIVIDER - 1));
  assign rot_tick_c   = frame_tick_c && (rot_cnt == RW'(RD - 1));

  // Frame and rotation-rate counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
      rot_cnt   <= '0;
    end else begin
      frame_cnt <= frame_tick_c ? '0 : frame_cnt + FW'(1);
      if (frame_tick_c) begin
        rot_cnt <= (rot_cnt == RW'(RD - 1)) ? '0 : rot_cnt + RW'(1);
      end
    end
  end

`ifdef SHIP_ROT_HOLD_EN
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} hold_state_t;

  hold_state_t   state, state_nxt;
  logic          hold_left, hold_left_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;

  // Hold-delay state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      hold_left <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      hold_left <= hold_left_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // First press steps at once, then waits HOLD_TICKS ticks before repeating
  always_comb begin
    state_nxt     = state;
    hold_left_nxt = hold_left;
    hold_cnt_nxt  = hold_cnt;
    step_up_c     = 1'b0;
    step_dn_c     = 1'b0;
    if (rot_tick_c) begin
      if (rot_left == rot_right) begin
        state_nxt    = S_IDLE;
        hold_cnt_nxt = '0;
      end else if (state == S_IDLE || rot_left != hold_left) begin
        step_up_c     = rot_left;
        step_dn_c     = rot_right;
        hold_left_nxt = rot_left;
        hold_cnt_nxt  = '0;
        state_nxt     = (HOLD_TICKS == 0) ? S_REPEAT : S_DELAY;
      end else if (state == S_DELAY) begin
        if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
          state_nxt    = S_REPEAT;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end else begin
        step_up_c = rot_left;
        step_dn_c = rot_right;
      end
    end
  end
`else
  // Step on every rotation tick while exactly one direction is held
  always_comb begin
    step_up_c = 1'b0;
    step_dn_c = 1'b0;
    if (rot_tick_c) begin
      step_up_c = rot_left & ~rot_right;
      step_dn_c = rot_right & ~rot_left;
    end
  end
`endif

  // Wrapping angle index
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      angle <= '0;
    end else if (step_up_c) begin
      angle <= angle + AW'(1);
    end else if (step_dn_c) begin
      angle <= angle - AW'(1);
    end
  end

  // Registered lookup; cos is sin a quarter turn ahead
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sin_val <= 18'sd0;
      cos_val <= 18'sd131071;
    end else begin
      sin_val <= fold(angle);
      cos_val <= fold(angle + AW'(QTR));
    end
  end

endmodule
